// File: rtl/seg_scan_if.sv
// seg_scan_if -- bus bundle for the 4-digit 7-segment scanner.
//   enable            : scan enable (synchronous to the scanner clock)
//   seg_in_0..3       : parallel segment codes, digit 0 (rightmost) .. digit 3
//   seg_out           : segment drive of the selected digit, bit0=a .. bit6=g
//   digit_sel         : one-hot digit enable, bit n = digit n
//   frame_done        : one-cycle pulse per completed 4-digit frame
// modport master drives enable/seg_in_*; modport slave is the scanner side.
interface seg_scan_if;
  logic       enable;
  logic [6:0] seg_in_0;
  logic [6:0] seg_in_1;
  logic [6:0] seg_in_2;
  logic [6:0] seg_in_3;
  logic [6:0] seg_out;
  logic [3:0] digit_sel;
  logic       frame_done;

  modport master (
    output enable, seg_in_0, seg_in_1, seg_in_2, seg_in_3,
    input  seg_out, digit_sel, frame_done
  );

  modport slave (
    input  enable, seg_in_0, seg_in_1, seg_in_2, seg_in_3,
    output seg_out, digit_sel, frame_done
  );
endinterface

// File: rtl/seg_scan.sv
// seg_scan -- time-multiplexed driver for a 4-digit 7-segment display.
// Each digit is preceded by BLANK_CYCLES of all-off (ghosting guard) and then
// shown for REFRESH_DIV cycles. The four input codes are snapshotted at frame
// start so a frame never mixes old and new values.
// Ports:
//   clk   : sole clock, rising edge
//   nrst  : asynchronous active-low reset
//   bus   : seg_scan_if.slave (enable, seg_in_0..3, seg_out, digit_sel, frame_done)
// All outputs are registered.
// Optional build macro: SEG_SCAN_LEADING_ZERO_BLANK_EN -- blank leading "0"
// codes (7'h3F) from digit 3 downward at snapshot time; digit 0 always shown.
module seg_scan #(
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic      clk,
  input  logic      nrst,
  seg_scan_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_e;

  localparam int unsigned MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  // Phase entered at the start of every digit slot
  localparam state_e FIRST = (BLANK_CYCLES == 0) ? SHOW : BLANK;

  state_e               state_q, state_d;
  logic [1:0]           idx_q, idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0][6:0]      snap_q, snap_d;
  logic [6:0]           seg_out_q, seg_out_d;
  logic [3:0]           digit_sel_q, digit_sel_d;
  logic                 frame_done_q, frame_done_d;
  logic [3:0][6:0]      raw;

  assign raw = {bus.seg_in_3, bus.seg_in_2, bus.seg_in_1, bus.seg_in_0};

  function automatic logic [3:0][6:0] capture(input logic [3:0][6:0] codes);
    logic [3:0][6:0] c;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    logic lead;
`endif
    c = codes;
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    // A digit is blanked only while every digit above it was a blanked "0"
    lead = 1'b1;
    for (int d = 3; d >= 1; d--) begin
      lead = lead && (codes[d] == 7'h3F);
      if (lead) c[d] = '0;
    end
`endif
    return c;
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    snap_d       = snap_q;
    frame_done_d = 1'b0;
    if (!bus.enable) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = FIRST;
          idx_d   = '0;
          cnt_d   = '0;
          snap_d  = capture(raw);
        end
        BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = FIRST;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            // End of digit 3 closes the frame; the next frame gets a new snapshot
            if (idx_q == 2'd3) begin
              frame_done_d = 1'b1;
              snap_d       = capture(raw);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // Outputs are decoded from the next state so they line up with it
    digit_sel_d = '0;
    seg_out_d   = '0;
    if (state_d == SHOW) begin
      digit_sel_d = 4'(4'b0001 << idx_d);
      seg_out_d   = snap_d[idx_d];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      snap_q       <= '0;
      seg_out_q    <= '0;
      digit_sel_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      snap_q       <= snap_d;
      seg_out_q    <= seg_out_d;
      digit_sel_q  <= digit_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg_out    = seg_out_q;
  assign bus.digit_sel  = digit_sel_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan -- two scanners (BLANK_CYCLES=1 and 0, REFRESH_DIV=4) share the
// same stimulus; every cycle both are compared with a frame-position model:
// position k in the frame gives digit k/(B+R) and blank when k%(B+R) < B.
module tb_seg_scan;
  localparam int R  = 4;
  localparam int B0 = 1;
  localparam int B1 = 0;

  logic       clk  = 1'b0;
  logic       nrst = 1'b0;
  logic       en   = 1'b0;
  logic [6:0] sin [4];

  int checks   = 0;
  int failures = 0;

  // reference model state
  int         blk [2];
  bit         act;
  int         k   [2];
  logic [6:0] snap[2][4];
  bit         fd  [2];

  always #5 clk = ~clk;

  seg_scan_if if0 ();
  seg_scan_if if1 ();

  assign if0.enable   = en;
  assign if0.seg_in_0 = sin[0];
  assign if0.seg_in_1 = sin[1];
  assign if0.seg_in_2 = sin[2];
  assign if0.seg_in_3 = sin[3];
  assign if1.enable   = en;
  assign if1.seg_in_0 = sin[0];
  assign if1.seg_in_1 = sin[1];
  assign if1.seg_in_2 = sin[2];
  assign if1.seg_in_3 = sin[3];

  seg_scan #(.REFRESH_DIV(R), .BLANK_CYCLES(B0)) u_dut0 (.clk(clk), .nrst(nrst), .bus(if0));
  seg_scan #(.REFRESH_DIV(R), .BLANK_CYCLES(B1)) u_dut1 (.clk(clk), .nrst(nrst), .bus(if1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic capture(input int i);
    bit lead;
    lead = 1'b1;
    for (int d = 3; d >= 0; d--) begin
      snap[i][d] = sin[d];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
      lead = lead && (d > 0) && (sin[d] == 7'h3F);
      if (lead) snap[i][d] = 7'h00;
`endif
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      fd[i] = 1'b0;
      if (!nrst) begin
        k[i] = 0;
        for (int d = 0; d < 4; d++) snap[i][d] = 7'h00;
      end else if (!en) begin
        k[i] = 0;
      end else if (!act) begin
        k[i] = 0;
        capture(i);
      end else begin
        k[i]++;
        if (k[i] == 4 * (blk[i] + R)) begin
          k[i]  = 0;
          fd[i] = 1'b1;
          capture(i);
        end
      end
    end
    act = nrst && en;
  endtask

  task automatic expect_out(input int i, output logic [3:0] es, output logic [6:0] eg);
    int d, w;
    es = 4'h0;
    eg = 7'h00;
    if (act) begin
      d = k[i] / (blk[i] + R);
      w = k[i] % (blk[i] + R);
      if (w >= blk[i]) begin
        es = 4'(1 << d);
        eg = snap[i][d];
      end
    end
  endtask

  task automatic cyc();
    logic [3:0] es;
    logic [6:0] eg;
    @(posedge clk);
    model_edge();
    #1;
    expect_out(0, es, eg);
    chk("b1_digit_sel",  32'(if0.digit_sel),  32'(es));
    chk("b1_seg_out",    32'(if0.seg_out),    32'(eg));
    chk("b1_frame_done", 32'(if0.frame_done), 32'(fd[0]));
    expect_out(1, es, eg);
    chk("b0_digit_sel",  32'(if1.digit_sel),  32'(es));
    chk("b0_seg_out",    32'(if1.seg_out),    32'(eg));
    chk("b0_frame_done", 32'(if1.frame_done), 32'(fd[1]));
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  // advance until the BLANK_CYCLES=1 scanner sits at frame position target
  task automatic wait_k0(input int target);
    for (int j = 0; j < 100 && !(act && k[0] == target); j++) cyc();
    chk("reach_pos", 32'(k[0]), 32'(target));
  endtask

  initial begin
    blk[0] = B0;
    blk[1] = B1;
    act    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      k[i] = 0; fd[i] = 1'b0;
      for (int d = 0; d < 4; d++) snap[i][d] = 7'h00;
    end
    for (int d = 0; d < 4; d++) sin[d] = 7'h00;

    // reset state
    run(3);
    nrst = 1'b1;
    run(2);

    // basic frame: 06,5B,4F,66
    sin[0] = 7'h06; sin[1] = 7'h5B; sin[2] = 7'h4F; sin[3] = 7'h66;
    en = 1'b1;
    run(45);

    // mid-frame input change must wait for the next frame
    wait_k0(12);
    sin[0] = 7'h7F;
    run(30);

    // abort on the last SHOW cycle of digit 3: no frame_done, restart at digit 0
    wait_k0(19);
    en = 1'b0;
    cyc();
    en = 1'b1;
    run(25);

    // asynchronous reset during digit-1 SHOW
    wait_k0(7);
    #2;
    nrst = 1'b0;
    #1;
    chk("rst_async_sel0", 32'(if0.digit_sel), 32'h0);
    chk("rst_async_seg0", 32'(if0.seg_out),   32'h0);
    chk("rst_async_sel1", 32'(if1.digit_sel), 32'h0);
    chk("rst_async_snap", 32'(u_dut0.snap_q), 32'h0);
    cyc();
    nrst = 1'b1;
    run(25);

    // leading-zero pattern (digits 3..0 = 3F,3F,06,3F)
    en = 1'b0;
    cyc();
    sin[3] = 7'h3F; sin[2] = 7'h3F; sin[1] = 7'h06; sin[0] = 7'h3F;
    en = 1'b1;
    run(25);

    // randomized inputs and occasional enable drops
    repeat (400) begin
      for (int d = 0; d < 4; d++)
        sin[d] = ($urandom_range(0, 2) == 0) ? 7'h3F : 7'($urandom);
      en = ($urandom_range(0, 29) != 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 1000, giving the clock cycles each digit is shown per frame (legal range 1 to 65535).
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 4, giving the clock cycles all digits are off before each digit is shown (legal range 0 to 255).
REQ-003 The block SHALL have these ports:
- clk  input  1  system clock; sole clock, rising edge.
- nrst  input  1  reset, asynchronous, active-low.
- enable  input  1  scan enable, synchronous.
- seg_in_0 .. seg_in_3  input  7 each  parallel segment codes for digit 0 (rightmost) to digit 3.
- seg_out  output  7  segment drive for the selected digit; bit0=a .. bit6=g, active-high.
- digit_sel  output  4  one-hot digit enable, active-high; bit n selects digit n.
- frame_done  output  1  one-cycle pulse at each completed 4-digit frame.

Function
REQ-004 All outputs SHALL be registered (Moore); they change only on a rising clk edge.
REQ-005 The FSM SHALL have three states: IDLE, BLANK and SHOW, with a 2-bit digit index idx and a phase counter wide enough for max(REFRESH_DIV, BLANK_CYCLES).
REQ-006 In IDLE: seg_out=0, digit_sel=0, idx=0, counter=0.
- enable sampled 1 -> next state BLANK, or SHOW when BLANK_CYCLES=0.
- On that transition, seg_in_0..3 are captured into the snapshot registers.
REQ-007 BLANK SHALL last exactly BLANK_CYCLES cycles with seg_out=0 and digit_sel=0, then go to SHOW.
REQ-008 SHOW SHALL last exactly REFRESH_DIV cycles with digit_sel = one-hot(idx) and seg_out = snapshot[idx].
REQ-009 After the last SHOW cycle, idx SHALL increment modulo 4 and the FSM SHALL return to BLANK (or SHOW when BLANK_CYCLES=0).
REQ-010 When the completed SHOW had idx=3:
- frame_done SHALL be 1 for exactly the following cycle.
- The snapshot SHALL be recaptured from seg_in_0..3 on the same edge.
REQ-011 Snapshot registers SHALL change only at frame start, so the inputs are tear-free within a frame; input changes mid-frame SHALL not appear until the next frame.
REQ-012 Frame period SHALL be exactly 4*(BLANK_CYCLES+REFRESH_DIV) cycles.
REQ-013 At most one digit_sel bit SHALL ever be 1.
REQ-014 digit_sel and seg_out SHALL never both be nonzero across a digit change without the intervening BLANK_CYCLES of zeros (when BLANK_CYCLES>0).
REQ-015 If enable is sampled 0 in any state, the next cycle SHALL be IDLE with all outputs 0, idx=0 and counter=0.
- No frame_done is emitted, even when the abort hits the final cycle of digit 3.
REQ-016 If enable is reasserted after an abort, scanning SHALL restart at digit 0 with a fresh snapshot, per REQ-006.

Reset
REQ-017 While nrst=0, the block SHALL immediately (asynchronously) force state=IDLE, idx=0, counter=0, snapshot=0, seg_out=0, digit_sel=0 and frame_done=0.
REQ-018 After nrst deasserts, the first possible non-IDLE state SHALL occur on the first rising edge with enable=1.
REQ-019 Reset asserted mid-frame SHALL abort the frame without a frame_done pulse.

Configuration
REQ-020 When macro SEG_SCAN_LEADING_ZERO_BLANK_EN is defined, leading-zero blanking SHALL apply at snapshot time. A digit is blanked when its code equals 7'h3F ("0") and all higher digits are blanked.
- Digit 3 is tested first.
- Digit 0 is never blanked.
- A blanked digit SHALL show seg_out=0, while digit_sel timing stays unchanged.
REQ-021 When the macro is undefined, all four snapshot codes SHALL be shown unmodified and no blanking logic SHALL be synthesized.

Verification (bench uses REFRESH_DIV=4, BLANK_CYCLES=1)
REQ-022 Stimulus: reset, enable=1, seg_in_0..3 = 06,5B,4F,66. Response:
- digit_sel pattern 0 then 0001 x4, 0 then 0010 x4, 0 then 0100 x4, 0 then 1000 x4.
- seg_out 06,5B,4F,66 in the matching windows.
- frame_done pulse 20 cycles after the first BLANK.
REQ-023 Stimulus: change seg_in_0 to 7F during digit-2 SHOW. Response: the current frame completes unchanged, and the next frame shows 7F on digit 0.
REQ-024 Stimulus: drop enable on the last SHOW cycle of digit 3. Response: outputs go to 0 the next cycle, no frame_done, and re-enable restarts at digit 0.
REQ-025 Stimulus: assert nrst=0 mid-SHOW of digit 1. Response: outputs go to 0 before the next clock edge, and the snapshot clears.
REQ-026 Stimulus: build with SEG_SCAN_LEADING_ZERO_BLANK_EN and inputs 3F,3F,06,3F (digits 3..0). Response: digits 3 and 2 show 00, digit 1 shows 06, digit 0 shows 3F. Without the macro, all four codes show unmodified.
REQ-027 Stimulus: BLANK_CYCLES=0. Response: digit_sel is never 0 while enabled, and the frame period is 16 cycles.
